// File: rtl/fpu_pkg.sv
// Shared FPU definitions: FP32 special-value constants and the multiply-arbiter FSM state type.
package fpu_pkg;

    localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP32_NEG_INF = 32'hFF80_0000;
    localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/multiplier.sv
// Combinational FP32 multiplier: subnormal operands flush to zero, round-to-nearest-even.
// Exception flags an Inf/NaN operand and forces a zero result; Overflow/Underflow saturate.
module multiplier (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow,
    output logic [31:0] result
);

    logic        sign_s;
    logic        zero_s;
    logic        guard_s;
    logic        sticky_s;
    logic        rnd_s;
    logic [23:0] man_a_s;
    logic [23:0] man_b_s;
    logic [23:0] man_rnd_s;
    logic [47:0] prod_s;
    logic [22:0] man_s;
    logic [9:0]  exp_s;

    assign sign_s    = a[31] ^ b[31];
    assign Exception = (&a[30:23]) | (&b[30:23]);
    assign zero_s    = (a[30:23] == 8'd0) | (b[30:23] == 8'd0);
    assign man_a_s   = {1'b1, a[22:0]};
    assign man_b_s   = {1'b1, b[22:0]};
    assign prod_s    = {24'd0, man_a_s} * {24'd0, man_b_s};

    // Normalise to 1.x and keep guard/sticky; a rounding carry bumps the exponent.
    assign man_s     = prod_s[47] ? prod_s[46:24] : prod_s[45:23];
    assign guard_s   = prod_s[47] ? prod_s[23] : prod_s[22];
    assign sticky_s  = prod_s[47] ? (|prod_s[22:0]) : (|prod_s[21:0]);
    assign rnd_s     = guard_s & (sticky_s | man_s[0]);
    assign man_rnd_s = {1'b0, man_s} + {23'd0, rnd_s};
    assign exp_s     = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127
                     + {9'd0, prod_s[47]} + {9'd0, man_rnd_s[23]};

    assign Overflow  = ~Exception & ~zero_s & ~exp_s[9] & (exp_s[8:0] >= 9'd255);
    assign Underflow = ~Exception & ~zero_s & (exp_s[9] | (exp_s == 10'd0));
    assign result    = Exception ? 32'd0 :
                       zero_s    ? {sign_s, 31'd0} :
                       Overflow  ? {sign_s, 8'hFF, 23'd0} :
                       Underflow ? {sign_s, 31'd0} :
                                   {sign_s, exp_s[7:0], man_rnd_s[22:0]};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr (wrapping) wins; one-hot + encoded grant.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    localparam logic [ID_W:0] N_VAL = (ID_W+1)'(N_REQ);

    logic [ID_W:0] sum_s;
    logic [ID_W:0] pos_s;
    logic          hit_s;
    logic          found_s;

    // Rotating priority search starting at ptr.
    always_comb begin
        gnt     = {N_REQ{1'b0}};
        idx     = {ID_W{1'b0}};
        found_s = 1'b0;
        sum_s   = {(ID_W+1){1'b0}};
        pos_s   = {(ID_W+1){1'b0}};
        hit_s   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            sum_s   = {1'b0, ptr} + (ID_W+1)'(k);
            pos_s   = (sum_s >= N_VAL) ? (sum_s - N_VAL) : sum_s;
            hit_s   = req[pos_s[ID_W-1:0]] & ~found_s;
            gnt     = gnt | ({{(N_REQ-1){1'b0}}, hit_s} << pos_s);
            idx     = hit_s ? pos_s[ID_W-1:0] : idx;
            found_s = found_s | hit_s;
        end
    end

    assign any = |req;

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one FP32 multiplier between N_REQ requesters with round-robin arbitration.
// Define FP_MUL_STICKY_FLAGS_EN to add the sticky_flags/sticky_clr accumulation port pair.
module fp_mul_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*32-1:0]   req_a,
    input  logic [N_REQ*32-1:0]   req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_result,
    output logic                  rsp_exception,
    output logic                  rsp_overflow,
    output logic                  rsp_underflow,
    output logic                  busy
`ifdef FP_MUL_STICKY_FLAGS_EN
    ,
    output logic [2:0]            sticky_flags,
    input  logic                  sticky_clr
`endif
);

    import fpu_pkg::*;

    arb_state_t       state_r;
    arb_state_t       state_nxt_s;
    logic [ID_W-1:0]  rr_ptr_r;
    logic [ID_W-1:0]  id_r;
    logic [ID_W-1:0]  gnt_idx_s;
    logic [N_REQ-1:0] gnt_s;
    logic             any_s;
    logic             grant_en_s;
    logic             grant_fire_s;
    logic [31:0]      op_a_r;
    logic [31:0]      op_b_r;
    logic [31:0]      mul_res_s;
    logic             mul_exc_s;
    logic             mul_ovf_s;
    logic             mul_unf_s;
    logic             rsp_valid_r;
    logic [ID_W-1:0]  rsp_id_r;
    logic [31:0]      rsp_result_r;
    logic             rsp_exc_r;
    logic             rsp_ovf_r;
    logic             rsp_unf_r;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req (req_valid),
        .ptr (rr_ptr_r),
        .gnt (gnt_s),
        .idx (gnt_idx_s),
        .any (any_s)
    );

    multiplier u_mul (
        .a         (op_a_r),
        .b         (op_b_r),
        .Exception (mul_exc_s),
        .Overflow  (mul_ovf_s),
        .Underflow (mul_unf_s),
        .result    (mul_res_s)
    );

    // A new op can be taken while idle or in the same cycle the pending response is consumed.
    assign grant_en_s   = (state_r == IDLE) || ((state_r == RESP) && rsp_ready);
    assign grant_fire_s = grant_en_s & any_s;
    assign req_ready    = grant_en_s ? gnt_s : {N_REQ{1'b0}};
    assign busy         = (state_r != IDLE);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: state_nxt_s = RESP;
            RESP: begin
                if (rsp_ready && any_s) begin
                    state_nxt_s = EXEC;
                end else if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand capture on grant, product capture in EXEC, response release on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r     <= {ID_W{1'b0}};
            id_r         <= {ID_W{1'b0}};
            op_a_r       <= FP32_ZERO;
            op_b_r       <= FP32_ZERO;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= {ID_W{1'b0}};
            rsp_result_r <= FP32_ZERO;
            rsp_exc_r    <= 1'b0;
            rsp_ovf_r    <= 1'b0;
            rsp_unf_r    <= 1'b0;
        end else begin
            if (grant_fire_s) begin
                op_a_r   <= req_a[{gnt_idx_s, 5'd0} +: 32];
                op_b_r   <= req_b[{gnt_idx_s, 5'd0} +: 32];
                id_r     <= gnt_idx_s;
                rr_ptr_r <= (gnt_idx_s == ID_W'(N_REQ-1)) ? {ID_W{1'b0}} : gnt_idx_s + ID_W'(1);
            end
            if (state_r == EXEC) begin
                rsp_valid_r  <= 1'b1;
                rsp_id_r     <= id_r;
                rsp_result_r <= mul_res_s;
                rsp_exc_r    <= mul_exc_s;
                rsp_ovf_r    <= mul_ovf_s;
                rsp_unf_r    <= mul_unf_s;
            end else if ((state_r == RESP) && rsp_ready) begin
                rsp_valid_r  <= 1'b0;
            end
        end
    end

    assign rsp_valid     = rsp_valid_r;
    assign rsp_id        = rsp_id_r;
    assign rsp_result    = rsp_result_r;
    assign rsp_exception = rsp_exc_r;
    assign rsp_overflow  = rsp_ovf_r;
    assign rsp_underflow = rsp_unf_r;

`ifdef FP_MUL_STICKY_FLAGS_EN
    logic [2:0] sticky_r;

    // Accumulates {exc, ovf, unf} of every captured product; a clear beats a same-cycle set.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_r <= 3'b000;
        end else if (sticky_clr) begin
            sticky_r <= 3'b000;
        end else if (state_r == EXEC) begin
            sticky_r <= sticky_r | {mul_exc_s, mul_ovf_s, mul_unf_s};
        end
    end

    assign sticky_flags = sticky_r;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench for fp_mul_arbiter: a cycle model predicts grants, rsp timing and fields.
module tb_fp_mul_arbiter;

    import fpu_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        logic        ovf;
        logic        unf;
        int          id;
    } item_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [31:0]     rsp_result;
    logic            rsp_exception;
    logic            rsp_overflow;
    logic            rsp_underflow;
    logic            busy;
`ifdef FP_MUL_STICKY_FLAGS_EN
    logic [2:0]      sticky_flags;
    logic            sticky_clr;
    logic [2:0]      m_sticky;
`endif

    int         checks   = 0;
    int         failures = 0;
    item_t      sb[$];
    int         glog[$];
    item_t      slot[N];
    bit         slot_v[N];
    arb_state_t m_state;
    int         m_ptr;

    fp_mul_arbiter #(.N_REQ(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_result    (rsp_result),
        .rsp_exception (rsp_exception),
        .rsp_overflow  (rsp_overflow),
        .rsp_underflow (rsp_underflow),
        .busy          (busy)
`ifdef FP_MUL_STICKY_FLAGS_EN
        ,
        .sticky_flags  (sticky_flags),
        .sticky_clr    (sticky_clr)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic item_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                                 input logic exc, input logic ovf, input logic unf);
        item_t it;
        it.a = a; it.b = b; it.res = r;
        it.exc = exc; it.ovf = ovf; it.unf = unf;
        it.id = 0;
        return it;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        int r;
        r = -1;
        for (int k = N - 1; k >= 0; k--) begin
            if (v[(ptr + k) % N]) r = (ptr + k) % N;
        end
        return r;
    endfunction

    function automatic bit pending();
        bit p;
        p = (sb.size() != 0) || (m_state != IDLE);
        for (int i = 0; i < N; i++) p = p | slot_v[i];
        return p;
    endfunction

    task automatic load(input int i, input item_t it);
        slot[i]    = it;
        slot[i].id = i;
        slot_v[i]  = 1'b1;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = slot_v[i];
            req_a[32*i +: 32]  = slot[i].a;
            req_b[32*i +: 32]  = slot[i].b;
        end
    endtask

    // One clock: drive, check at negedge against the model, advance the model, wait past posedge.
    task automatic cycle();
        item_t        e;
        int           g;
        logic [N-1:0] exp_rdy;
        drive();
        @(negedge clk);
        if (rst) begin
            m_state = IDLE;
            m_ptr   = 0;
            sb.delete();
`ifdef FP_MUL_STICKY_FLAGS_EN
            m_sticky = 3'b000;
`endif
        end else begin
            check_eq("rsp_valid", rsp_valid, (m_state == RESP));
            check_eq("busy", busy, (m_state != IDLE));
`ifdef FP_MUL_STICKY_FLAGS_EN
            check_eq("sticky_flags", sticky_flags, m_sticky);
            if (sticky_clr) m_sticky = 3'b000;
            else if (m_state == EXEC && sb.size() > 0) begin
                e = sb[sb.size() - 1];
                m_sticky = m_sticky | {e.exc, e.ovf, e.unf};
            end
`endif
            if (m_state == RESP && sb.size() > 0) begin
                e = sb[0];
                check_eq("rsp_id", rsp_id, e.id);
                check_eq("rsp_result", rsp_result, e.res);
                check_eq("rsp_exception", rsp_exception, e.exc);
                check_eq("rsp_overflow", rsp_overflow, e.ovf);
                check_eq("rsp_underflow", rsp_underflow, e.unf);
                if (rsp_ready) void'(sb.pop_front());
            end
            g = -1;
            if (m_state == IDLE || (m_state == RESP && rsp_ready)) g = rr_pick(req_valid, m_ptr);
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check_eq("req_ready", req_ready, exp_rdy);
            for (int i = 0; i < N; i++) if (req_ready[i]) glog.push_back(i);
            case (m_state)
                IDLE:    m_state = (g >= 0) ? EXEC : IDLE;
                EXEC:    m_state = RESP;
                RESP:    m_state = rsp_ready ? ((g >= 0) ? EXEC : IDLE) : RESP;
                default: m_state = IDLE;
            endcase
            if (g >= 0) begin
                sb.push_back(slot[g]);
                slot_v[g] = 1'b0;
                m_ptr = (g + 1) % N;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) slot_v[i] = 1'b0;
        cycle();
        rst = 1'b0;
        drive();
    endtask

    task automatic check_reset_vals();
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_rsp_id", rsp_id, 2'd0);
        check_eq("rst_rsp_result", rsp_result, FP32_ZERO);
        check_eq("rst_flags", {rsp_exception, rsp_overflow, rsp_underflow}, 3'b000);
        check_eq("rst_req_ready", req_ready, 4'b0000);
`ifdef FP_MUL_STICKY_FLAGS_EN
        check_eq("rst_sticky", sticky_flags, 3'b000);
`endif
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            cycle();
            n++;
        end
        check_eq("drain_timeout", (n < budget), 1'b1);
    endtask

    initial begin
        item_t i_2x3, i_1x1, i_2x2, i_3x3, i_n1x5, i_bp, i_exc, i_ovf, i_unf;
        i_2x3  = mk(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0, 1'b0);
        i_1x1  = mk(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0);
        i_2x2  = mk(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0, 1'b0, 1'b0);
        i_3x3  = mk(32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 1'b0, 1'b0, 1'b0);
        i_n1x5 = mk(32'hBF80_0000, 32'h40A0_0000, 32'hC0A0_0000, 1'b0, 1'b0, 1'b0);
        i_bp   = mk(32'h3FC0_0000, 32'hC000_0000, 32'hC040_0000, 1'b0, 1'b0, 1'b0);
        i_exc  = mk(FP32_POS_INF, FP32_NEG_INF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        i_ovf  = mk(32'h7F00_0000, 32'h7F00_0000, FP32_POS_INF, 1'b0, 1'b1, 1'b0);
        i_unf  = mk(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1);

        rst       = 1'b1;
        rsp_ready = 1'b0;
        m_state   = IDLE;
        m_ptr     = 0;
`ifdef FP_MUL_STICKY_FLAGS_EN
        sticky_clr = 1'b0;
        m_sticky   = 3'b000;
`endif
        for (int i = 0; i < N; i++) begin
            slot[i]   = i_1x1;
            slot_v[i] = 1'b0;
        end
        drive();
        do_reset();
        check_reset_vals();
        rsp_ready = 1'b1;

        // Single op: 2.0 * 3.0
        load(0, i_2x3);
        run_until_idle(20);

        // All four requesters at once from a fresh pointer
        do_reset();
        glog.delete();
        load(0, i_1x1); load(1, i_2x2); load(2, i_3x3); load(3, i_n1x5);
        run_until_idle(40);
        check_eq("t2_grants", glog.size(), 4);
        for (int k = 0; k < 4; k++) if (k < glog.size()) check_eq("t2_order", glog[k], k);

        // Backpressure on req1's response while req2 waits
        load(1, i_bp);
        cycle();
        cycle();
        rsp_ready = 1'b0;
        load(2, i_exc);
        repeat (5) cycle();
        rsp_ready = 1'b1;
        run_until_idle(20);

        // Overflow and underflow flags
        load(3, i_ovf);
        run_until_idle(20);
        load(0, i_unf);
        run_until_idle(20);
        repeat (2) cycle();
`ifdef FP_MUL_STICKY_FLAGS_EN
        sticky_clr = 1'b1;
        cycle();
        sticky_clr = 1'b0;
        load(2, i_exc);
        cycle();
        sticky_clr = 1'b1;
        cycle();
        sticky_clr = 1'b0;
        run_until_idle(20);
`endif

        // Reset while an op is in EXEC: it must never respond, and the pointer restarts at 0
        load(2, i_3x3);
        cycle();
        do_reset();
        check_reset_vals();
        repeat (4) cycle();
        glog.delete();
        load(0, i_1x1); load(3, i_n1x5);
        run_until_idle(20);
        check_eq("t5_grants", glog.size(), 2);
        if (glog.size() == 2) begin
            check_eq("t5_first", glog[0], 0);
            check_eq("t5_second", glog[1], 3);
        end

        // Wrap-around after a grant to the last requester
        glog.delete();
        load(3, i_2x2);
        cycle();
        load(0, i_1x1); load(3, i_3x3);
        run_until_idle(20);
        check_eq("t6_grants", glog.size(), 3);
        if (glog.size() == 3) begin
            check_eq("t6_g0", glog[0], 3);
            check_eq("t6_g1", glog[1], 0);
            check_eq("t6_g2", glog[2], 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
